// File: rtl/serv_rf_ram_clr_if.sv
// Register-file RAM bus between the SERV register-file interface (master)
// and the clearing RAM (slave).
//   waddr : write address            (master -> slave)
//   wdata : write data               (master -> slave)
//   wen   : write enable             (master -> slave)
//   raddr : read address             (master -> slave)
//   rdata : registered read data     (slave  -> master)
interface serv_rf_ram_clr_if #(
  parameter int width = 8,
  parameter int aw    = 7
);
  logic [aw-1:0]    waddr;
  logic [width-1:0] wdata;
  logic             wen;
  logic [aw-1:0]    raddr;
  logic [width-1:0] rdata;

  modport master (output waddr, output wdata, output wen, output raddr, input rdata);
  modport slave  (input waddr, input wdata, input wen, input raddr, output rdata);
endinterface

// File: rtl/serv_rf_ram_clr.sv
// Register-file RAM for the SERV bit-serial core with self-clearing and
// per-word even parity. After reset (or an i_clr pulse) every word is walked
// and written with zero; while that walk runs o_busy is high and user
// writes/reads are ignored. Read data is registered (1-cycle latency,
// read-before-write) and checked against the stored parity bit.
//   i_clk      : clock
//   i_rst_n    : asynchronous active-low reset
//   bus        : waddr/wdata/wen/raddr in, rdata out (slave modport)
//   i_clr      : single-cycle request to re-clear the whole RAM
//   i_perr_inj : with a write, store inverted parity
//   o_busy     : high while the clear walk is in progress
//   o_perr     : parity error on the word currently on rdata
//   o_perr_cnt : saturating count of parity errors (reset only)
module serv_rf_ram_clr #(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int depth    = 32*(16+csr_regs)/width,
  parameter int aw       = $clog2(depth)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  serv_rf_ram_clr_if.slave        bus,
  input  logic                    i_clr,
  input  logic                    i_perr_inj,
  output logic                    o_busy,
  output logic                    o_perr,
  output logic [7:0]              o_perr_cnt
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  // One extra bit so the range compare also works when depth == 2**aw.
  localparam logic [aw:0]   depth_w   = (aw+1)'(depth);
  localparam logic [aw-1:0] last_addr = aw'(depth - 1);

  state_t           state_reg, state_next;
  logic [aw-1:0]    clr_addr_reg, clr_addr_next;

  logic             mem_we;
  logic [aw-1:0]    mem_waddr;
  logic [width:0]   mem_wdata;
  logic             rd_en;

  // {parity, data}; intentionally without reset so it maps onto block RAM.
  logic [width:0]   mem [0:depth-1];

  logic [width:0]   rword_reg;
  logic             rd_valid_reg;
  logic             waddr_ok;
  logic             raddr_ok;

  assign waddr_ok = {1'b0, bus.waddr} < depth_w;
  assign raddr_ok = {1'b0, bus.raddr} < depth_w;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    mem_we        = 1'b0;
    mem_waddr     = clr_addr_reg;
    mem_wdata     = '0;
    rd_en         = 1'b0;
    case (state_reg)
      CLEAR: begin
        // Clear walk owns the write port; user writes are ignored.
        mem_we        = 1'b1;
        clr_addr_next = clr_addr_reg + aw'(1);
        if (clr_addr_reg == last_addr) begin
          state_next = READY;
        end
        if (i_clr) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
        end
      end
      READY: begin
        if (bus.wen && waddr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = bus.waddr;
          mem_wdata = {(^bus.wdata) ^ i_perr_inj, bus.wdata};
        end
        // The read register is zeroed on the edge that enters CLEAR.
        rd_en = !i_clr;
        if (i_clr) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
        end
      end
      default: begin
        state_next    = CLEAR;
        clr_addr_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Old contents are captured on a same-address write (read-before-write).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rword_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else if (rd_en) begin
      rword_reg    <= raddr_ok ? mem[bus.raddr] : '0;
      rd_valid_reg <= 1'b1;
    end else begin
      rword_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end
  end

  assign bus.rdata = rword_reg[width-1:0];
  assign o_perr    = rd_valid_reg & (^rword_reg);
  assign o_busy    = (state_reg == CLEAR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perr_cnt <= '0;
    end else if (o_perr && (o_perr_cnt != 8'hFF)) begin
      o_perr_cnt <= o_perr_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_clr.sv
// Self-checking bench for serv_rf_ram_clr with default parameters
// (width 8, depth 80, aw 7). Reads push the expected word to a queue when
// driven; each test pops and compares once the registered output appears.
module tb_serv_rf_ram_clr;

  localparam int DEPTH = 80;

  logic       clk;
  logic       rst_n;
  logic       i_clr;
  logic       i_perr_inj;
  logic       o_busy;
  logic       o_perr;
  logic [7:0] perr_cnt;

  serv_rf_ram_clr_if #(.width(8), .aw(7)) bus ();

  serv_rf_ram_clr dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .i_clr      (i_clr),
    .i_perr_inj (i_perr_inj),
    .o_busy     (o_busy),
    .o_perr     (o_perr),
    .o_perr_cnt (perr_cnt)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         addr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_data [DEPTH];
  bit         m_bad  [DEPTH];
  int         tests;
  int         fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic model_zero();
    for (int a = 0; a < DEPTH; a++) begin
      m_data[a] = 8'h00;
      m_bad[a]  = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus; a read pushes its expected result.
  task automatic drive(input bit wen, input int waddr, input logic [7:0] wdata,
                       input bit inj, input bit clr, input bit rd, input int raddr);
    exp_t e;
    bus.wen    = wen;
    bus.waddr  = 7'(waddr);
    bus.wdata  = wdata;
    bus.raddr  = 7'(raddr);
    i_perr_inj = inj;
    i_clr      = clr;
    if (rd) begin
      if (raddr < DEPTH) begin
        e.data = m_data[raddr];
        e.perr = m_bad[raddr];
      end else begin
        e.data = 8'h00;
        e.perr = 1'b0;
      end
      e.addr = raddr;
      exp_q.push_back(e);
    end
    if (wen && waddr < DEPTH) begin
      m_data[waddr] = wdata;
      m_bad[waddr]  = inj;
    end
    @(posedge clk);
    #1;
    bus.wen    = 1'b0;
    i_perr_inj = 1'b0;
    i_clr      = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    i_clr = 1'b0; i_perr_inj = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL reset_busy got=%b want=1", o_busy); end
    tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got=%h want=00", bus.rdata); end
    tests++; if (o_perr !== 1'b0) begin fails++; $display("FAIL reset_perr got=%b want=0", o_perr); end
    tests++; if (perr_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got=%0d want=0", perr_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!o_busy) break;
    end
    tests++; if (n != DEPTH) begin fails++; $display("FAIL reset_clear_cycles got=%0d want=%0d", n, DEPTH); end
    $display("[TB] reset: busy fell after %0d cycles", n);
  endtask

  task automatic test_walk(input string tag);
    exp_t e;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, a);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.rdata !== e.data || o_perr !== e.perr) begin
          fails++;
          $display("FAIL %s addr=%0d got rdata=%h perr=%b want rdata=%h perr=%b",
                   tag, e.addr, bus.rdata, o_perr, e.data, e.perr);
        end
      end
    end
    $display("[TB] %s: read %0d words", tag, DEPTH);
  endtask

  task automatic test_write_read();
    exp_t e;
    // Same-cycle write and read returns the old word.
    drive(1'b1, 17, 8'hA5, 1'b0, 1'b0, 1'b1, 17);
    e = exp_q.pop_front();
    tests++;
    if (bus.rdata !== 8'h00 || o_perr !== 1'b0 || e.data !== 8'h00) begin
      fails++; $display("FAIL rbw got rdata=%h perr=%b want rdata=00 perr=0", bus.rdata, o_perr);
    end
    $display("[TB] rbw: addr 17 rdata=%h", bus.rdata);
    drive(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 17);
    e = exp_q.pop_front();
    tests++;
    if (bus.rdata !== e.data || o_perr !== e.perr) begin
      fails++; $display("FAIL write_read got rdata=%h perr=%b want rdata=%h perr=%b", bus.rdata, o_perr, e.data, e.perr);
    end
    $display("[TB] write_read: addr 17 rdata=%h", bus.rdata);
  endtask

  task automatic test_parity_inj();
    exp_t e;
    drive(1'b1, 5, 8'h3C, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 5);
      e = exp_q.pop_front();
      tests++;
      if (bus.rdata !== e.data || o_perr !== e.perr) begin
        fails++; $display("FAIL perr_inj rd%0d got rdata=%h perr=%b want rdata=%h perr=%b", i, bus.rdata, o_perr, e.data, e.perr);
      end
      $display("[TB] perr_inj: read %0d rdata=%h perr=%b", i, bus.rdata, o_perr);
    end
    drive(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    tests++; if (perr_cnt !== 8'd3) begin fails++; $display("FAIL perr_cnt3 got=%0d want=3", perr_cnt); end
    drive(1'b1, 5, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 5);
    e = exp_q.pop_front();
    tests++;
    if (bus.rdata !== e.data || o_perr !== e.perr) begin
      fails++; $display("FAIL perr_fixed got rdata=%h perr=%b want rdata=%h perr=%b", bus.rdata, o_perr, e.data, e.perr);
    end
    drive(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    tests++; if (perr_cnt !== 8'd3) begin fails++; $display("FAIL perr_cnt_hold got=%0d want=3", perr_cnt); end
    $display("[TB] perr_inj: count=%0d", perr_cnt);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] d;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      drive(1'b1, 20 + i, d, 1'b0, 1'b0, 1'b1, (i == 0) ? 20 : 19 + i);
      e = exp_q.pop_front();
      tests++;
      if (bus.rdata !== e.data || o_perr !== e.perr) begin
        fails++; $display("FAIL b2b addr=%0d got rdata=%h perr=%b want rdata=%h perr=%b", e.addr, bus.rdata, o_perr, e.data, e.perr);
      end
      $display("[TB] b2b: wr %0d=%h rd %0d=%h", 20 + i, d, e.addr, bus.rdata);
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    drive(1'b1, 100, 8'hFF, 1'b0, 1'b0, 1'b1, 100);
    e = exp_q.pop_front();
    drive(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 100);
    e = exp_q.pop_front();
    tests++;
    if (bus.rdata !== e.data || o_perr !== e.perr) begin
      fails++; $display("FAIL oor got rdata=%h perr=%b want rdata=%h perr=%b", bus.rdata, o_perr, e.data, e.perr);
    end
    $display("[TB] oor: addr 100 rdata=%h perr=%b", bus.rdata, o_perr);
  endtask

  task automatic test_runtime_clear();
    int n;
    for (int a = 0; a < DEPTH; a++) drive(1'b1, a, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL clr_busy got=%b want=1", o_busy); end
    n = 0;
    while (n < 200) begin
      // Write an already-cleared word; it must be ignored.
      bus.wen   = 1'b1;
      bus.waddr = 7'((n + DEPTH - 1) % DEPTH);
      bus.wdata = 8'hAA;
      bus.raddr = 7'(n % DEPTH);
      @(posedge clk); #1;
      n++;
      if (bus.rdata !== 8'h00 || o_perr !== 1'b0) begin
        tests++; fails++;
        $display("FAIL clr_outputs cycle=%0d got rdata=%h perr=%b want rdata=00 perr=0", n, bus.rdata, o_perr);
      end
      if (!o_busy) break;
    end
    bus.wen = 1'b0;
    tests++; if (n != DEPTH) begin fails++; $display("FAIL clr_cycles got=%0d want=%0d", n, DEPTH); end
    $display("[TB] runtime_clear: busy for %0d cycles", n);
    model_zero();
    test_walk("after_clear");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    drive(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL midrst_busy got=%b want=1", o_busy); end
    tests++; if (perr_cnt !== 8'd0) begin fails++; $display("FAIL midrst_cnt got=%0d want=0", perr_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!o_busy) break;
    end
    tests++; if (n != DEPTH) begin fails++; $display("FAIL midrst_cycles got=%0d want=%0d", n, DEPTH); end
    tests++; if (perr_cnt !== 8'd0) begin fails++; $display("FAIL midrst_cnt_after got=%0d want=0", perr_cnt); end
    $display("[TB] reset_mid_clear: busy for %0d cycles, count=%0d", n, perr_cnt);
    model_zero();
  endtask

  task automatic test_saturation();
    exp_t e;
    int   bad;
    drive(1'b1, 9, 8'h11, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 305; i++) begin
      drive(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 9);
      e = exp_q.pop_front();
      tests++;
      if (bus.rdata !== e.data || o_perr !== e.perr) begin
        fails++; $display("FAIL sat_read%0d got rdata=%h perr=%b want rdata=%h perr=%b", i, bus.rdata, o_perr, e.data, e.perr);
      end
      if (i == 9 || i == 299 || i == 304) begin
        drive(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        bad = (i + 1 > 255) ? 255 : i + 1;
        tests++;
        if (perr_cnt !== 8'(bad)) begin
          fails++; $display("FAIL sat_cnt after %0d reads got=%0d want=%0d", i + 1, perr_cnt, bad);
        end
        $display("[TB] saturation: %0d bad reads, count=%0d", i + 1, perr_cnt);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_walk("walk");
    test_write_read();
    test_parity_inj();
    test_back_to_back();
    test_out_of_range();
    test_runtime_clear();
    test_reset_mid_clear();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
